// File: rtl/product_skid_reg_pkg.sv
// Shared definitions for the product skid register: FSM encoding and default sizes.
package product_skid_reg_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Occupancy reported on the count port for a given state.
    function automatic logic [1:0] state_count(input state_e st);
        logic [1:0] cnt;
        case (st)
            ST_EMPTY: cnt = 2'd0;
            ST_ONE:   cnt = 2'd1;
            ST_TWO:   cnt = 2'd2;
            default:  cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/product_field_reg.sv
// One {a0, a1} storage entry with load enable and synchronous reset to INIT values.
module product_field_reg #(
    parameter int                       WIDTH   = 8,
    parameter logic                     INIT_A0 = 1'b1,
    parameter logic signed [WIDTH-1:0]  INIT_A1 = WIDTH'(32'sd2)
) (
    input  logic                    real_clk,
    input  logic                    real_rst,
    input  logic                    en,
    input  logic                    d_a0,
    input  logic signed [WIDTH-1:0] d_a1,
    output logic                    q_a0,
    output logic signed [WIDTH-1:0] q_a1
);

    logic                    a0_r;
    logic signed [WIDTH-1:0] a1_r;

    // Entry storage: reset to INIT, otherwise load when enabled.
    always_ff @(posedge real_clk) begin
        if (real_rst) begin
            a0_r <= INIT_A0;
            a1_r <= INIT_A1;
        end else if (en) begin
            a0_r <= d_a0;
            a1_r <= d_a1;
        end else begin
            a0_r <= a0_r;
            a1_r <= a1_r;
        end
    end

    assign q_a0 = a0_r;
    assign q_a1 = a1_r;

endmodule

// File: rtl/product_skid_reg.sv
// Two-entry skid register carrying a {flag, signed data} product with fully registered handshake outputs.
module product_skid_reg
    import product_skid_reg_pkg::*;
#(
    parameter int                       WIDTH   = DEF_WIDTH,
    parameter logic                     INIT_A0 = 1'b1,
    parameter logic signed [WIDTH-1:0]  INIT_A1 = WIDTH'(32'sd2),
    parameter int                       CNT_W   = DEF_CNT_W
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    I_valid,
    output logic                    I_ready,
    input  logic                    I_a0,
    input  logic signed [WIDTH-1:0] I_a1,
    output logic                    O_valid,
    input  logic                    O_ready,
    output logic                    O_a0,
    output logic signed [WIDTH-1:0] O_a1,
    output logic [1:0]              count,
    output logic [CNT_W-1:0]        xfer_count
);

    state_e                  state_r;
    state_e                  next_state_s;
    logic                    o_valid_r;
    logic                    i_ready_r;
    logic [1:0]              count_r;
    logic [CNT_W-1:0]        xfer_count_r;

    logic                    in_fire_s;
    logic                    out_fire_s;
    logic                    main_en_s;
    logic                    main_from_skid_s;
    logic                    skid_en_s;
    logic                    main_d_a0_s;
    logic signed [WIDTH-1:0] main_d_a1_s;
    logic                    main_a0_s;
    logic signed [WIDTH-1:0] main_a1_s;
    logic                    skid_a0_s;
    logic signed [WIDTH-1:0] skid_a1_s;

    assign in_fire_s  = I_valid & i_ready_r;
    assign out_fire_s = o_valid_r & O_ready;

    // Next-state and entry load decisions from the current state and both fires.
    always_comb begin
        next_state_s     = state_r;
        main_en_s        = 1'b0;
        main_from_skid_s = 1'b0;
        skid_en_s        = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    main_en_s    = 1'b1;
                    next_state_s = ST_ONE;
                end else begin
                    next_state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_fire_s && !out_fire_s) begin
                    skid_en_s    = 1'b1;
                    next_state_s = ST_TWO;
                end else if (in_fire_s && out_fire_s) begin
                    main_en_s    = 1'b1;
                    next_state_s = ST_ONE;
                end else if (out_fire_s) begin
                    next_state_s = ST_EMPTY;
                end else begin
                    next_state_s = ST_ONE;
                end
            end
            ST_TWO: begin
                if (out_fire_s) begin
                    main_en_s        = 1'b1;
                    main_from_skid_s = 1'b1;
                    next_state_s     = ST_ONE;
                end else begin
                    next_state_s = ST_TWO;
                end
            end
            default: begin
                next_state_s = ST_EMPTY;
            end
        endcase
    end

    assign main_d_a0_s = main_from_skid_s ? skid_a0_s : I_a0;
    assign main_d_a1_s = main_from_skid_s ? skid_a1_s : I_a1;

    // FSM state plus handshake flags registered from the next state, so no input reaches them combinationally.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= ST_EMPTY;
            o_valid_r <= 1'b0;
            i_ready_r <= 1'b1;
            count_r   <= 2'd0;
        end else begin
            state_r   <= next_state_s;
            o_valid_r <= (next_state_s != ST_EMPTY);
            i_ready_r <= (next_state_s != ST_TWO);
            count_r   <= state_count(next_state_s);
        end
    end

    // Output transfer counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            xfer_count_r <= '0;
        end else if (out_fire_s) begin
            xfer_count_r <= xfer_count_r + CNT_W'(1);
        end else begin
            xfer_count_r <= xfer_count_r;
        end
    end

    product_field_reg #(
        .WIDTH   (WIDTH),
        .INIT_A0 (INIT_A0),
        .INIT_A1 (INIT_A1)
    ) u_main (
        .real_clk (CLK),
        .real_rst (RESET),
        .en       (main_en_s),
        .d_a0     (main_d_a0_s),
        .d_a1     (main_d_a1_s),
        .q_a0     (main_a0_s),
        .q_a1     (main_a1_s)
    );

    product_field_reg #(
        .WIDTH   (WIDTH),
        .INIT_A0 (INIT_A0),
        .INIT_A1 (INIT_A1)
    ) u_skid (
        .real_clk (CLK),
        .real_rst (RESET),
        .en       (skid_en_s),
        .d_a0     (I_a0),
        .d_a1     (I_a1),
        .q_a0     (skid_a0_s),
        .q_a1     (skid_a1_s)
    );

    assign O_valid    = o_valid_r;
    assign I_ready    = i_ready_r;
    assign count      = count_r;
    assign xfer_count = xfer_count_r;
    assign O_a0       = main_a0_s;
    assign O_a1       = main_a1_s;

endmodule

// File: tb/tb_product_skid_reg.sv
// Directed table-driven bench for product_skid_reg; expected values are post-edge state per vector.
module tb_product_skid_reg;

    logic              CLK;
    logic              RESET;
    logic              I_valid;
    logic              I_ready;
    logic              I_a0;
    logic signed [7:0] I_a1;
    logic              O_valid;
    logic              O_ready;
    logic              O_a0;
    logic signed [7:0] O_a1;
    logic [1:0]        count;
    logic [3:0]        xfer_count;

    int n_vec  = 0;
    int n_miss = 0;

    product_skid_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .I_valid    (I_valid),
        .I_ready    (I_ready),
        .I_a0       (I_a0),
        .I_a1       (I_a1),
        .O_valid    (O_valid),
        .O_ready    (O_ready),
        .O_a0       (O_a0),
        .O_a1       (O_a1),
        .count      (count),
        .xfer_count (xfer_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic              rst;
        logic              iv;
        logic              a0;
        logic signed [7:0] a1;
        logic              ordy;
        logic              e_ov;
        logic              e_ir;
        logic [1:0]        e_cnt;
        logic              e_a0;
        logic signed [7:0] e_a1;
        logic [3:0]        e_x;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic drive(input logic rst, input logic iv, input logic a0,
                         input logic signed [7:0] a1, input logic ordy);
        RESET   = rst;
        I_valid = iv;
        I_a0    = a0;
        I_a1    = a1;
        O_ready = ordy;
    endtask

    task automatic check(input string name, input logic e_ov, input logic e_ir,
                         input logic [1:0] e_cnt, input logic e_a0,
                         input logic signed [7:0] e_a1, input logic [3:0] e_x);
        n_vec++;
        if (O_valid !== e_ov || I_ready !== e_ir || count !== e_cnt ||
            O_a0 !== e_a0 || O_a1 !== e_a1 || xfer_count !== e_x) begin
            n_miss++;
            $display("FAIL %s: got ov=%b ir=%b cnt=%0d a0=%b a1=%0d x=%0d, want ov=%b ir=%b cnt=%0d a0=%b a1=%0d x=%0d",
                     name, O_valid, I_ready, count, O_a0, O_a1, xfer_count,
                     e_ov, e_ir, e_cnt, e_a0, e_a1, e_x);
        end
    endtask

    initial begin
        //               rst   iv    a0    a1        ordy  ov    ir    cnt   a0    a1         x
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'sd0,    1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 8'sd2,    4'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'sd9,    1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 8'sd2,    4'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'sd5,    1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'sd5,    4'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, -8'sd3,   1'b1, 1'b1, 1'b1, 2'd1, 1'b0, -8'sd3,   4'd1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'sd127,  1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'sd127,  4'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'sd0,    1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 8'sd127,  4'd3};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'sd0,    1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 8'sd127,  4'd3};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'sd10,   1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 8'sd10,   4'd3};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'sd20,   1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 8'sd10,   4'd3};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'sd99,   1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 8'sd10,   4'd3};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'sd0,    1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'sd20,   4'd4};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'sd0,    1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 8'sd20,   4'd5};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 8'sd7,    1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'sd7,    4'd5};
        vecs[13] = '{1'b0, 1'b1, 1'b0, -8'sd8,   1'b1, 1'b1, 1'b1, 2'd1, 1'b0, -8'sd8,   4'd6};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'sd0,    1'b1, 1'b0, 1'b1, 2'd0, 1'b0, -8'sd8,   4'd7};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 8'sd33,   1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'sd33,   4'd7};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 8'sd44,   1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 8'sd33,   4'd7};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 8'sd0,    1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 8'sd2,    4'd0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 8'sd0,    1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 8'sd2,    4'd0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 8'sd0,    1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 8'sd2,    4'd0};

        drive(1'b1, 1'b0, 1'b0, 8'sd0, 1'b0);
        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            drive(vecs[i].rst, vecs[i].iv, vecs[i].a0, vecs[i].a1, vecs[i].ordy);
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_cnt,
                  vecs[i].e_a0, vecs[i].e_a1, vecs[i].e_x);
        end

        // Handshake flags must not react to inputs within a cycle.
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b0, 8'sd1, 1'b1);
        #1;
        check("no_comb_path", 1'b0, 1'b1, 2'd0, 1'b1, 8'sd2, 4'd0);

        // Wrap: 17 transfers through a 4-bit counter from a fresh reset.
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b0, 8'sd0, 1'b1);
        @(posedge CLK);
        #1;
        check("wrap_reset", 1'b0, 1'b1, 2'd0, 1'b1, 8'sd2, 4'd0);
        for (int k = 0; k < 17; k++) begin
            logic signed [7:0] v;
            v = 8'(-60 + 7 * k);
            @(negedge CLK);
            drive(1'b0, 1'b1, k[0], v, 1'b1);
            @(posedge CLK);
            #1;
            check($sformatf("stream%0d", k), 1'b1, 1'b1, 2'd1, k[0], v, 4'(k));
        end
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 8'sd0, 1'b1);
        @(posedge CLK);
        #1;
        check("wrap_final", 1'b0, 1'b1, 2'd0, 1'b0, 8'sd52, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
